systolic_pe_q: RTL
==================

# systolic_pe_q

Parametrised, stallable signed fixed-point MAC processing element for the systolic array. It is the successor to the fixed Q1.15 PE and adds the following:
- configurable data, fraction and accumulator widths;
- runtime weight-stationary or output-stationary mode;
- optional round-to-nearest;
- a saturating accumulator with a sticky saturation flag;
- a valid/ready result-drain handshake, so results leave the tile without a global read mux.

## Interface
- DATA_BITS, 16, operand/result width, signed two's complement
- FRAC_BITS, 15, fractional bits of operands and result (0 ≤ FRAC_BITS < DATA_BITS)
- ACC_BITS, 32, accumulator width; must be ≥ 2*DATA_BITS − FRAC_BITS + 1
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global advance; 0 freezes every register, FSM and handshake
- mode  in  1  0 = weight-stationary (a_in × weight_reg), 1 = output-stationary (a_in × b_in)
- round_en  in  1  1 = round-half-up on product rescale, 0 = truncate
- load_weight  in  1  weight_reg ← b_in
- clear_acc  in  1  zero accumulator, sticky flag and in-flight products
- in_valid  in  1  a_in/b_in carry an operand pair to accumulate
- a_in, b_in  in  DATA_BITS  operands
- a_out, b_out  out  DATA_BITS  registered pass-through to neighbours
- valid_out  out  1  registered in_valid to neighbour
- drain  in  1  request result emission
- res_data  out  DATA_BITS  saturated result
- res_sat  out  1  result clamped or accumulator saturated during this accumulation
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- busy  out  1  FSM not IDLE

## Operation
- Every cycle with enable=1, the pass-through registers update regardless of FSM state: a_out←a_in, b_out←b_in, valid_out←in_valid.
- load_weight updates weight_reg in any state. With mode=0, a pair entering in the same cycle as load_weight uses the old weight.
- Pipeline:
  - S0 registers the signed operands (a_in and the b_in/weight_reg pick per mode) plus a valid bit.
  - S1 registers the rescaled product: the full 2*DATA_BITS signed product, plus 2^(FRAC_BITS−1) when round_en=1 and FRAC_BITS>0, then arithmetic shift right by FRAC_BITS, sign-extended to ACC_BITS.
  - S2 adds it to the accumulator.
- The accumulator saturates at ±(2^(ACC_BITS−1)) bounds: max 2^(ACC_BITS−1)−1, min −2^(ACC_BITS−1). It never wraps. Any clamp sets the sticky flag.
- Result: the accumulator is clamped to [−2^(DATA_BITS−1), 2^(DATA_BITS−1)−1]. Output clamping also sets res_sat.
- FSM states and transitions:
  - IDLE: in_valid is accepted. drain=1 (with clear_acc=0) → FLUSH.
  - FLUSH: in_valid is ignored. When S0 and S1 both hold no valid, do the following in a single edge, then → HOLD:
    - res_data ← clamped accumulator;
    - res_sat ← sticky | output clamp;
    - accumulator and sticky ← 0.
  - HOLD: in_valid is ignored; res_valid=1. On res_ready=1 → IDLE, with res_valid deasserting on that edge.
- clear_acc is acted on only in IDLE. It zeroes the accumulator, the sticky flag and the S0/S1 valids, and has priority over both in_valid and drain in the same cycle: the input pair is discarded and drain is ignored. In FLUSH and HOLD, clear_acc is ignored.
- res_data and res_sat hold their value from capture until the next capture.

## Timing
- Reset: all outputs 0 (a_out, b_out, valid_out, res_data, res_sat, res_valid, busy); weight_reg, pipeline, accumulator and sticky flag are 0; FSM in IDLE.
- Reset is asynchronous: asserting it mid-accumulation or mid-HOLD discards everything immediately, including a held result.
- Pass-through latency is 1 cycle.
- Accumulation latency is 3 enabled edges: a pair sampled at edge N is reflected in the accumulator after edge N+2.
- Drain latency with an empty pipe: drain sampled at edge N → FLUSH; capture at edge N+1, so res_valid=1 after N+1. With pairs in flight, capture waits until the last in-flight pair has accumulated.
- A result is transferred on an edge where enable, res_valid and res_ready are all 1. res_ready is ignored while enable=0.
- busy=1 in FLUSH and HOLD, registered with the state.
- enable=0 holds all state. Pipeline valids are not lost across stalls.

## Test plan
- Defaults, mode=0: load weight 0x4000, then one pair a=0x4000, then drain with res_ready=1 → res_data=0x2000, res_sat=0, res_valid high exactly one cycle.
- Rounding, mode=1: a=0x0001, b=0x4000. round_en=0 → res_data=0x0000; round_en=1 → res_data=0x0001.
- Clamp, mode=1: a=b=0x8000 once → accumulator 32768, res_data=0x7FFF, res_sat=1. Same with b=0x7FFF → res_data=0x8001, res_sat=0.
- Accumulator saturation, ACC_BITS=18: four pairs 0x8000×0x8000 → accumulator clamps at 0x1FFFF, res_data=0x7FFF, res_sat=1. The next accumulation after drain starts from 0.
- Handshake and priority:
  - drain while 2 pairs are in flight → both are included; in_valid during FLUSH/HOLD has no effect.
  - res_ready=0 for 5 cycles → res_valid and res_data are stable.
  - clear_acc together with in_valid and drain in IDLE → accumulator stays 0, no drain.
- Stall/reset: enable=0 for 3 cycles mid-pipeline → same final result as without the stall, and a_out is frozen. reset_n low during HOLD → res_valid=0 and busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/systolic_pe_q_if.sv
// -----------------------------------------------------------------------------
// systolic_pe_q_if
// Result-drain handshake between a systolic PE and the downstream collector.
//   res_data   : saturated result word (signed, DATA_BITS)
//   res_sat    : result was clamped or the accumulator saturated
//   res_valid  : result available
//   res_ready  : consumer accepts the result
// master = PE side (drives result), slave = consumer side (drives ready).
// -----------------------------------------------------------------------------
interface systolic_pe_q_if #(
   parameter int DATA_BITS = 16
);
   logic [DATA_BITS-1:0] res_data;
   logic                 res_sat;
   logic                 res_valid;
   logic                 res_ready;

   modport master (
      output res_data,
      output res_sat,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_sat,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/systolic_pe_q.sv
// -----------------------------------------------------------------------------
// systolic_pe_q
// Stallable signed fixed-point MAC processing element. Three-stage pipeline
// (operand register, rescaled product, saturating accumulate) with runtime
// weight-/output-stationary operand selection, optional round-half-up and a
// valid/ready drain of the clamped result.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable              : global advance; 0 freezes every register
//   mode                : 0 = a_in x weight_reg, 1 = a_in x b_in
//   round_en            : 1 = round-half-up when rescaling the product
//   load_weight         : weight_reg <- b_in
//   clear_acc           : zero accumulator, sticky flag and in-flight pairs (IDLE only)
//   in_valid, a_in, b_in: operand pair to accumulate
//   a_out, b_out        : registered operand pass-through to neighbours
//   valid_out           : registered in_valid to neighbour
//   drain               : request result emission
//   busy                : FSM not IDLE
//   res_if              : result handshake (res_data, res_sat, res_valid, res_ready)
// -----------------------------------------------------------------------------
module systolic_pe_q #(
   parameter int DATA_BITS = 16,
   parameter int FRAC_BITS = 15,
   parameter int ACC_BITS  = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 mode,
   input  logic                 round_en,
   input  logic                 load_weight,
   input  logic                 clear_acc,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] a_in,
   input  logic [DATA_BITS-1:0] b_in,
   output logic [DATA_BITS-1:0] a_out,
   output logic [DATA_BITS-1:0] b_out,
   output logic                 valid_out,
   input  logic                 drain,
   output logic                 busy,
   systolic_pe_q_if.master      res_if
);

   localparam int PW = 2 * DATA_BITS;
   // Working width for the shift: wide enough for the full product and the accumulator.
   localparam int EW = (ACC_BITS > PW) ? ACC_BITS : PW;

   localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};
   // Half an LSB of the rescaled result; evaluates to zero when FRAC_BITS is 0.
   localparam logic [PW-1:0] RND_K = (ONE_P << FRAC_BITS) >> 1;

   localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
   localparam logic signed [ACC_BITS-1:0] OUT_MAX =
      {{(ACC_BITS-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] OUT_MIN =
      {{(ACC_BITS-DATA_BITS+1){1'b1}}, {(DATA_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Saturating add; MSB of the return value flags a clamp.
   function automatic logic [ACC_BITS:0] sat_add(input logic signed [ACC_BITS-1:0] x,
                                                 input logic signed [ACC_BITS-1:0] y);
      logic [ACC_BITS:0] s;
      s = {x[ACC_BITS-1], x} + {y[ACC_BITS-1], y};
      if (s[ACC_BITS] != s[ACC_BITS-1]) begin
         if (s[ACC_BITS]) begin
            return {1'b1, ACC_MIN};
         end else begin
            return {1'b1, ACC_MAX};
         end
      end else begin
         return {1'b0, ACC_BITS'(s)};
      end
   endfunction

   // Clamp the accumulator to the result word range; MSB flags a clamp.
   function automatic logic [DATA_BITS:0] clamp_out(input logic signed [ACC_BITS-1:0] x);
      if (x > OUT_MAX) begin
         return {1'b1, DATA_BITS'(OUT_MAX)};
      end else if (x < OUT_MIN) begin
         return {1'b1, DATA_BITS'(OUT_MIN)};
      end else begin
         return {1'b0, DATA_BITS'(x)};
      end
   endfunction

   state_t                       state_q, state_d;
   logic                         busy_q, busy_d;
   logic [DATA_BITS-1:0]         a_out_q, a_out_d, b_out_q, b_out_d;
   logic                         valid_out_q, valid_out_d;
   logic [DATA_BITS-1:0]         weight_q, weight_d;
   logic signed [DATA_BITS-1:0]  s0_a_q, s0_a_d, s0_b_q, s0_b_d;
   logic                         s0_v_q, s0_v_d;
   logic signed [ACC_BITS-1:0]   s1_p_q, s1_p_d;
   logic                         s1_v_q, s1_v_d;
   logic signed [ACC_BITS-1:0]   acc_q, acc_d;
   logic                         sticky_q, sticky_d;
   logic [DATA_BITS-1:0]         res_data_q, res_data_d;
   logic                         res_sat_q, res_sat_d;
   logic                         res_valid_q, res_valid_d;

   logic signed [PW-1:0]         prod_s, rnd_s;
   logic signed [EW-1:0]         ext_s, shf_s;
   logic [ACC_BITS:0]            add_s;
   logic [DATA_BITS:0]           out_s;
   logic                         clear_s, accept_s;

   // Next-state logic for the pipeline, accumulator, drain FSM and outputs.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      a_out_d     = a_out_q;
      b_out_d     = b_out_q;
      valid_out_d = valid_out_q;
      weight_d    = weight_q;
      s0_a_d      = s0_a_q;
      s0_b_d      = s0_b_q;
      s0_v_d      = s0_v_q;
      s1_p_d      = s1_p_q;
      s1_v_d      = s1_v_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      res_data_d  = res_data_q;
      res_sat_d   = res_sat_q;
      res_valid_d = res_valid_q;

      clear_s  = (state_q == ST_IDLE) && clear_acc;
      accept_s = (state_q == ST_IDLE) && in_valid && !clear_acc;

      prod_s = PW'(s0_a_q) * PW'(s0_b_q);
      rnd_s  = prod_s + (round_en ? RND_K : {PW{1'b0}});
      ext_s  = EW'(rnd_s);
      shf_s  = ext_s >>> FRAC_BITS;
      add_s  = sat_add(acc_q, s1_p_q);
      out_s  = clamp_out(acc_q);

      if (enable) begin
         a_out_d     = a_in;
         b_out_d     = b_in;
         valid_out_d = in_valid;

         if (load_weight) begin
            weight_d = b_in;
         end else begin
            weight_d = weight_q;
         end

         // Operands follow the inputs every cycle; only the valid bit qualifies them.
         // weight_q here is the pre-load value, so a simultaneous load is not seen.
         s0_a_d = a_in;
         s0_b_d = mode ? b_in : weight_q;
         s0_v_d = accept_s;
         s1_p_d = ACC_BITS'(shf_s);
         s1_v_d = s0_v_q && !clear_s;

         if (clear_s) begin
            acc_d    = {ACC_BITS{1'b0}};
            sticky_d = 1'b0;
         end else if (s1_v_q) begin
            acc_d    = add_s[ACC_BITS-1:0];
            sticky_d = sticky_q | add_s[ACC_BITS];
         end else begin
            acc_d    = acc_q;
            sticky_d = sticky_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (drain && !clear_acc) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FLUSH: begin
               // Capture only once every in-flight pair has reached the accumulator.
               if (!s0_v_q && !s1_v_q) begin
                  res_data_d = out_s[DATA_BITS-1:0];
                  res_sat_d  = sticky_q | out_s[DATA_BITS];
                  acc_d      = {ACC_BITS{1'b0}};
                  sticky_d   = 1'b0;
                  state_d    = ST_HOLD;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            ST_HOLD: begin
               if (res_if.res_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         busy_d      = (state_d != ST_IDLE);
         res_valid_d = (state_d == ST_HOLD);
      end else begin
         state_d = state_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         a_out_q     <= {DATA_BITS{1'b0}};
         b_out_q     <= {DATA_BITS{1'b0}};
         valid_out_q <= 1'b0;
         weight_q    <= {DATA_BITS{1'b0}};
         s0_a_q      <= {DATA_BITS{1'b0}};
         s0_b_q      <= {DATA_BITS{1'b0}};
         s0_v_q      <= 1'b0;
         s1_p_q      <= {ACC_BITS{1'b0}};
         s1_v_q      <= 1'b0;
         acc_q       <= {ACC_BITS{1'b0}};
         sticky_q    <= 1'b0;
         res_data_q  <= {DATA_BITS{1'b0}};
         res_sat_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         valid_out_q <= valid_out_d;
         weight_q    <= weight_d;
         s0_a_q      <= s0_a_d;
         s0_b_q      <= s0_b_d;
         s0_v_q      <= s0_v_d;
         s1_p_q      <= s1_p_d;
         s1_v_q      <= s1_v_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         res_data_q  <= res_data_d;
         res_sat_q   <= res_sat_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign a_out            = a_out_q;
   assign b_out            = b_out_q;
   assign valid_out        = valid_out_q;
   assign busy             = busy_q;
   assign res_if.res_data  = res_data_q;
   assign res_if.res_sat   = res_sat_q;
   assign res_if.res_valid = res_valid_q;

endmodule
